// File: rtl/block_ram_tx_reader.sv
// Streams len bytes from the block RAM read port into the UART TX byte handshake.
// Latency: start -> first tx_valid in 3 cycles; handshake -> next tx_valid in 3 cycles.
// Backpressure: tx_data/tx_valid are held stable until tx_ready; abort drops everything.
module block_ram_tx_reader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_BYTES  = 1024,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, LOAD, SEND} state_t;

  // Highest valid RAM address; reads wrap back to zero after it.
  localparam logic [ADDR_WIDTH-1:0] MEM_LAST  = ADDR_WIDTH'(MEM_BYTES - 1);
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_BYTES);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;

  logic                    base_ok;
  logic [ADDR_WIDTH-1:0]   next_addr;

  assign base_ok   = {1'b0, base_addr} < MEM_LIMIT;
  assign next_addr = (rd_addr_q == MEM_LAST) ? '0 : rd_addr_q + ADDR_WIDTH'(1);

  // Next-state and registered-output computation; abort overrides every active state.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;

    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      tx_valid_d = 1'b0;
      rem_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort && base_ok) begin
            if (len == '0) begin
              // Empty telegram: acknowledge immediately without touching the RAM.
              done_d = 1'b1;
            end else begin
              rd_addr_d = base_addr;
              rem_d     = len;
              busy_d    = 1'b1;
              state_d   = WAIT;
            end
          end
        end
        WAIT: begin
          // RAM registers rd_addr on this edge; data appears during LOAD.
          state_d = LOAD;
        end
        LOAD: begin
          tx_data_d  = rd_data;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
        SEND: begin
          if (tx_ready) begin
            rem_d      = rem_q - LEN_WIDTH'(1);
            tx_valid_d = 1'b0;
            if (rem_q == LEN_WIDTH'(1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              rd_addr_d = next_addr;
              state_d   = WAIT;
            end
          end
        end
        default: begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          tx_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers, cleared asynchronously by nreset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_addr  = rd_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: tb/tb_block_ram_tx_reader.sv
// Scoreboard bench for block_ram_tx_reader: stimulus pushes expected bytes/addresses,
// a negedge monitor pops and compares on each handshake and checks latency/stability.
// Includes a registered-read RAM model and a tx_ready pattern generator.
module tb_block_ram_tx_reader;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MB = 1024;
  localparam int LW = 9;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic          abort = 1'b0;
  logic          busy, done, tx_valid;
  logic          tx_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] tx_data;

  block_ram_tx_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB), .LEN_WIDTH(LW)) dut (
    .clk(clk), .nreset(nreset), .start(start), .base_addr(base_addr), .len(len),
    .abort(abort), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Block RAM read port: one-cycle registered read.
  logic [7:0] mem [0:MB-1];
  always @(posedge clk) rd_data <= mem[rd_addr % MB];

  int checks = 0;
  int errors = 0;
  logic [7:0]    exp_data_q [$];
  logic [AW-1:0] exp_addr_q [$];
  int cyc_cnt = 0;
  int event_cyc = -100;
  int hs_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc_cnt++;
    if (!nreset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (tx_valid && !prev_valid) chk("valid_latency", cyc_cnt - event_cyc, 3);
      if (tx_valid && prev_valid && !prev_hs) chk("tx_data_stable", tx_data, prev_data);
      if (done) begin
        done_cnt++;
        chk("done_latency", cyc_cnt - event_cyc, 1);
        chk("busy_low_at_done", busy, 0);
      end
      if (start && !busy && !abort) event_cyc = cyc_cnt;
      if (tx_valid && tx_ready && !abort) begin
        hs_cnt++;
        event_cyc = cyc_cnt;
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          chk("tx_data", tx_data, exp_data_q.pop_front());
          chk("rd_addr", rd_addr, exp_addr_q.pop_front());
        end
      end
      prev_valid = tx_valid;
      prev_hs    = tx_valid && tx_ready && !abort;
      prev_data  = tx_data;
    end
  end

  // tx_ready generator: 0 = always ready, 1 = five stall cycles per byte, 2 = never ready.
  initial begin
    int hold = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: tx_ready = 1'b1;
        1: begin
          if (tx_valid) begin
            if (hold < 5) begin tx_ready = 1'b0; hold++; end
            else begin tx_ready = 1'b1; hold = 0; end
          end else begin
            tx_ready = 1'b0;
            hold = 0;
          end
        end
        default: tx_ready = 1'b0;
      endcase
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [AW-1:0] a);
    exp_data_q.push_back(d);
    exp_addr_q.push_back(a);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    base_addr = b;
    len = l;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_data_q.size() != 0) && n < 500) begin
      cyc();
      n++;
    end
    chk({name, "_timeout"}, (n < 500) ? 1 : 0, 1);
    cyc();
    cyc();
  endtask

  task automatic run_xfer(input string name, input logic [AW-1:0] b, input logic [LW-1:0] l);
    int d0 = done_cnt;
    do_start(b, l);
    chk({name, "_busy"}, busy, 1);
    wait_idle(name);
    chk({name, "_done_count"}, done_cnt - d0, 1);
    chk({name, "_queue_empty"}, exp_data_q.size(), 0);
  endtask

  task automatic push_basic();
    push(8'hA1, 16'h10);
    push(8'hB2, 16'h11);
    push(8'hC3, 16'h12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, h0, n;
    for (int i = 0; i < MB; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'hA1; mem[16'h11] = 8'hB2; mem[16'h12] = 8'hC3;
    mem[1022] = 8'h11; mem[1023] = 8'h22; mem[0] = 8'h33; mem[1] = 8'h44;
    for (int i = 0; i < 10; i++) mem[256 + i] = 8'(8'h60 + i);
    mem[512] = 8'h5A;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    nreset = 1'b1;
    cyc();
    cyc();

    // Basic transfer
    push_basic();
    run_xfer("basic", 16'h10, 3);

    // Backpressure: five stall cycles per byte
    rdy_mode = 1;
    push_basic();
    run_xfer("backpressure", 16'h10, 3);
    rdy_mode = 0;
    cyc();

    // Ring wrap at end of RAM
    push(8'h11, 16'd1022);
    push(8'h22, 16'd1023);
    push(8'h33, 16'd0);
    push(8'h44, 16'd1);
    run_xfer("wrap", 16'd1022, 4);

    // Length zero: done next cycle, no busy, no byte
    d0 = done_cnt;
    do_start(16'h10, 0);
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_tx_valid", tx_valid, 0);
    cyc();
    chk("len0_done_clear", done, 0);
    cyc();
    chk("len0_done_count", done_cnt - d0, 1);

    // Bad base address: ignored
    d0 = done_cnt;
    do_start(16'd1024, 3);
    chk("badbase_busy", busy, 0);
    cyc(); cyc(); cyc(); cyc();
    chk("badbase_tx_valid", tx_valid, 0);
    chk("badbase_done_count", done_cnt - d0, 0);

    // abort together with start in IDLE: abort wins
    base_addr = 16'h10; len = 3; start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    cyc();

    // Abort while the 3rd of 10 bytes is in SEND
    d0 = done_cnt;
    h0 = hs_cnt;
    for (int i = 0; i < 10; i++) push(8'(8'h60 + i), 16'(256 + i));
    do_start(16'd256, 10);
    n = 0;
    while (!(hs_cnt == h0 + 2 && tx_valid) && n < 100) begin
      cyc();
      n++;
    end
    chk("abort_reach_timeout", (n < 100) ? 1 : 0, 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    exp_data_q.delete();
    exp_addr_q.delete();
    cyc(); cyc(); cyc();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_bytes_sent", hs_cnt - h0, 2);
    push(8'h5A, 16'd512);
    run_xfer("after_abort", 16'd512, 1);

    // Asynchronous reset during SEND
    rdy_mode = 2;
    cyc();
    do_start(16'h10, 3);
    n = 0;
    while (!tx_valid && n < 20) begin
      cyc();
      n++;
    end
    chk("reset_reach_send", tx_valid, 1);
    cyc();
    #2;
    nreset = 1'b0;
    #1;
    chk("areset_tx_valid", tx_valid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_done", done, 0);
    chk("areset_rd_addr", rd_addr, 0);
    #3;
    nreset = 1'b1;
    rdy_mode = 0;
    cyc();
    cyc();
    push_basic();
    run_xfer("post_reset", 16'h10, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
